// File: rtl/ser_byte_rx.sv
// ser_byte_rx: serial-to-parallel word receiver with a small FWFT FIFO.
//
// Consumes one bit per cycle while bit_valid is high, assembles framed words
// of WIDTH bits (frame_start marks bit 0), and queues them for a parallel
// consumer. Overflow and framing faults are reported as sticky flags.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   serial_in    data bit, sampled when bit_valid=1
//   bit_valid    bit strobe
//   frame_start  current bit is bit 0 of a new word (qualified by bit_valid)
//   rd_en        pop head word (ignored while empty)
//   dout         FIFO head (fall-through), reads 0 while empty
//   empty/full   FIFO occupancy status
//   count        number of stored words
//   overflow     sticky: completed word dropped because FIFO was full
//   frame_err    sticky: partial frame aborted by an early frame_start
module ser_byte_rx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          bit_valid,
  input  logic                          frame_start,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [CW-1:0]     bitcnt;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic              first, mid, push, do_push, do_pop;
  logic [CW-1:0]     idx;
  logic [WIDTH-1:0]  word;

  // Next assembly value including the bit accepted this cycle; on the
  // completing edge this is exactly the word that goes into the FIFO.
  always_comb begin
    first = bit_valid && frame_start;
    mid   = bit_valid && !frame_start && (state == SHIFT);
    idx   = first ? '0 : bitcnt;
    if (MSB_FIRST != 0) idx = TOP - idx;
    word  = first ? '0 : shreg;
    if (first || mid) word[idx] = serial_in;
    push  = (first && (WIDTH == 1)) || (mid && (bitcnt == TOP));
  end

  // A full FIFO still accepts a word when the head is popped on the same edge.
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (first) begin
        if (state == SHIFT) frame_err <= 1'b1;
        shreg <= word;
        if (WIDTH == 1) begin
          state  <= IDLE;
          bitcnt <= '0;
        end else begin
          state  <= SHIFT;
          bitcnt <= CW'(1);
        end
      end else if (mid) begin
        shreg <= word;
        if (bitcnt == TOP) begin
          state  <= IDLE;
          bitcnt <= '0;
        end else begin
          bitcnt <= bitcnt + CW'(1);
        end
      end

      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !do_push) overflow <= 1'b1;

      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= word;
  end

  assign empty = (count == '0);
  assign full  = (count == CNTW'(FIFO_DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ser_byte_rx.sv
// tb_ser_byte_rx: scoreboard bench for ser_byte_rx. Two instances share all
// inputs: one LSB-first, one MSB-first. Expected words are queued when a
// frame is sent; a negedge monitor checks dout whenever a pop is issued.
module tb_ser_byte_rx;
  logic clk = 0;
  logic rst, serial_in, bit_valid, frame_start, rd_en;
  logic [7:0] dout_l, dout_m;
  logic empty_l, full_l, ovf_l, ferr_l;
  logic empty_m, full_m, ovf_m, ferr_m;
  logic [2:0] count_l, count_m;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] sb_l[$];
  logic [7:0] sb_m[$];

  always #5 clk = ~clk;

  ser_byte_rx #(.WIDTH(8), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .rd_en(rd_en), .dout(dout_l), .empty(empty_l),
    .full(full_l), .count(count_l), .overflow(ovf_l), .frame_err(ferr_l));

  ser_byte_rx #(.WIDTH(8), .MSB_FIRST(1), .FIFO_DEPTH(4)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .rd_en(rd_en), .dout(dout_m), .empty(empty_m),
    .full(full_m), .count(count_m), .overflow(ovf_m), .frame_err(ferr_m));

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop is committed on the next rising edge, so the head seen
  // now must be the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty_l) begin
      if (sb_l.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL pop_lsb: got %0h expected no word", dout_l);
      end else chk("pop_lsb", {24'h0, dout_l}, {24'h0, sb_l.pop_front()});
    end
    if (!rst && rd_en && !empty_m) begin
      if (sb_m.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL pop_msb: got %0h expected no word", dout_m);
      end else chk("pop_msb", {24'h0, dout_m}, {24'h0, sb_m.pop_front()});
    end
  end

  task automatic cyc(input logic bv, input logic fs, input logic si, input logic rd);
    @(posedge clk); #1;
    bit_valid = bv; frame_start = fs; serial_in = si; rd_en = rd;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0);
  endtask

  // Bits go out w[0] first; rd_last raises rd_en on the final bit's cycle.
  task automatic send(input logic [7:0] w, input logic rd_last);
    for (int i = 0; i < 8; i++) cyc(1, i == 0, w[i], rd_last && (i == 7));
  endtask

  task automatic exp_word(input logic [7:0] w);
    sb_l.push_back(w);
    sb_m.push_back(rev8(w));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; bit_valid = 1; frame_start = 1; serial_in = 1; rd_en = 1;
    @(posedge clk); #1;
    rst = 0; bit_valid = 0; frame_start = 0; serial_in = 0; rd_en = 0;
    sb_l.delete(); sb_m.delete();
    @(negedge clk);
    chk("rst_count", count_l, 0);
    chk("rst_empty", empty_l, 1);
    chk("rst_full", full_l, 0);
    chk("rst_ovf", ovf_l, 0);
    chk("rst_ferr", ferr_l, 0);
    chk("rst_dout", dout_l, 0);
    chk("rst_count_m", count_m, 0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    idle();
  endtask

  initial begin
    rst = 1; serial_in = 0; bit_valid = 0; frame_start = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // 0x13 LSB-first; the MSB-first instance sees the mirror 0xC8
    send(8'h13, 0); exp_word(8'h13); idle();
    @(negedge clk);
    chk("t1_dout", dout_l, 8'h13);
    chk("t1_count", count_l, 1);
    chk("t1_empty", empty_l, 0);
    chk("t1_dout_m", dout_m, 8'hC8);
    pop_n(1);
    @(negedge clk);
    chk("t1_empty_after", empty_l, 1);

    // bits 0,0,0,1,0,0,1,1 -> MSB-first instance assembles 0x13
    send(8'hC8, 0); exp_word(8'hC8); idle();
    @(negedge clk);
    chk("t2_dout_m", dout_m, 8'h13);
    pop_n(1);

    // overflow: four fill the FIFO, the fifth is dropped
    do_reset();
    for (int w = 1; w <= 4; w++) begin send(8'(w), 0); exp_word(8'(w)); end
    idle();
    @(negedge clk);
    chk("t3_full", full_l, 1);
    chk("t3_count", count_l, 4);
    chk("t3_ovf_pre", ovf_l, 0);
    send(8'h05, 0); idle();
    @(negedge clk);
    chk("t3_ovf", ovf_l, 1);
    chk("t3_ovf_m", ovf_m, 1);
    chk("t3_count_post", count_l, 4);
    pop_n(4);
    @(negedge clk);
    chk("t3_empty", empty_l, 1);

    // early frame_start after 3 bits aborts that frame
    do_reset();
    cyc(1, 1, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 0);
    send(8'hA5, 0); exp_word(8'hA5); idle();
    @(negedge clk);
    chk("t4_ferr", ferr_l, 1);
    chk("t4_ferr_m", ferr_m, 1);
    chk("t4_count", count_l, 1);
    chk("t4_ovf", ovf_l, 0);
    pop_n(1);

    // full FIFO, word completes with rd_en: pop and push both succeed
    do_reset();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    exp_word(8'h11); exp_word(8'h22); exp_word(8'h33); exp_word(8'h44);
    send(8'h55, 1); exp_word(8'h55); idle();
    @(negedge clk);
    chk("t5_count", count_l, 4);
    chk("t5_ovf", ovf_l, 0);
    chk("t5_full", full_l, 1);
    chk("t5_head", dout_l, 8'h22);
    pop_n(4);
    @(negedge clk);
    chk("t5_empty", empty_l, 1);

    // reset mid-frame with words queued, then a clean frame
    do_reset();
    send(8'h0F, 0); send(8'hF0, 0); exp_word(8'h0F); exp_word(8'hF0);
    cyc(1, 1, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 0);
    do_reset();
    send(8'h3C, 0); exp_word(8'h3C); idle();
    @(negedge clk);
    chk("t6_count", count_l, 1);
    chk("t6_dout", dout_l, 8'h3C);
    chk("t6_dout_m", dout_m, 8'h3C);
    pop_n(1);

    @(negedge clk);
    chk("sb_lsb_drained", sb_l.size(), 0);
    chk("sb_msb_drained", sb_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
